// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encodings and ASCII constants.
// Optional feature macro: UART_ARB_PREFIX_EN (adds the PFX0/PFX1 line-prefix states).
package uart_arb_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_PFX0  = 3'd3;
   localparam logic [2:0] ST_PFX1  = 3'd4;

   localparam logic [7:0] NL         = 8'h0A;
   localparam logic [7:0] COLON      = 8'h3A;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StIssue = ST_ISSUE,
      StDrain = ST_DRAIN
`ifdef UART_ARB_PREFIX_EN
      ,
      StPfx0  = ST_PFX0,
      StPfx1  = ST_PFX1
`endif
   } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning ptr, ptr+1, ... (mod N_REQ).
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   grant,
   output logic             any
);

   // Walk the requesters starting at ptr with wrap-around; first hit wins.
   always_comb begin
      logic [IDW-1:0] idx;
      grant = '0;
      any   = 1'b0;
      idx   = ptr;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!any && valid[idx]) begin
            any   = 1'b1;
            grant = idx;
         end
         idx = (idx == IDW'(N_REQ - 1)) ? '0 : idx + IDW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-serial UART transmitter between N_REQ requesters with round-robin grant and a
// per-line lock (held until '\n' or LOCK_TIMEOUT idle cycles).
// Optional feature macro: UART_ARB_PREFIX_EN (prefixes each new line with "<index>:").
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned LOCK_TIMEOUT = 4096,
   localparam int unsigned TO_W        = $clog2(LOCK_TIMEOUT + 1),
   localparam int unsigned IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         tx_data,
   output logic               tx_we,
   input  logic               tx_ready,
   output logic [IDW-1:0]     owner,
   output logic               locked
);

   arb_state_e     state;
   logic [TO_W-1:0] to_cnt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] pick_idx;
   logic           pick_any;
   logic           grant_en;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] next_ptr;
   logic [7:0]     req_bytes [N_REQ];
`ifdef UART_ARB_PREFIX_EN
   logic [7:0]     data_hold;
   logic [1:0]     pfx_left;   // prefix bytes still owed before the data byte
`endif

   uart_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_idx),
      .any   (pick_any)
   );

   // Byte view of the packed request data bus.
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_bytes[i] = req_data[8*i +: 8];
      end
   end

   // Grant decision, only meaningful in IDLE with the transmitter ready.
   always_comb begin
      grant_en  = 1'b0;
      grant_idx = pick_idx;
      if (state == StIdle && tx_ready) begin
         if (locked) begin
            if (req_valid[owner]) begin
               grant_en  = 1'b1;
               grant_idx = owner;
            end
         end else begin
            grant_en = pick_any;
         end
      end
   end

   assign next_ptr = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);

   // Arbiter FSM with registered transmitter/requester outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         req_ready <= '0;
         tx_data   <= '0;
         tx_we     <= 1'b0;
         owner     <= '0;
         locked    <= 1'b0;
         rr_ptr    <= '0;
         to_cnt    <= '0;
`ifdef UART_ARB_PREFIX_EN
         data_hold <= '0;
         pfx_left  <= '0;
`endif
      end else begin
         req_ready <= '0;
         unique case (state)
            StIdle: begin
               if (grant_en) begin
                  owner  <= grant_idx;
                  locked <= 1'b1;
                  to_cnt <= '0;
                  rr_ptr <= next_ptr;
                  tx_we  <= 1'b1;
`ifdef UART_ARB_PREFIX_EN
                  if (!locked) begin
                     // New line: send "<g>:" first; data byte is captured now.
                     tx_data   <= ASCII_ZERO + 8'(grant_idx);
                     data_hold <= req_bytes[grant_idx];
                     pfx_left  <= 2'd2;
                     state     <= StPfx0;
                  end else begin
`else
                  begin
`endif
                     tx_data              <= req_bytes[grant_idx];
                     req_ready[grant_idx] <= 1'b1;
                     state                <= StIssue;
                  end
               end else if (tx_ready && locked) begin
                  // Owner idle while holding the lock: count towards release.
                  if (to_cnt + TO_W'(1) == TO_W'(LOCK_TIMEOUT)) begin
                     locked <= 1'b0;
                     to_cnt <= '0;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
            end
`ifdef UART_ARB_PREFIX_EN
            StIssue, StPfx0, StPfx1: begin
`else
            StIssue: begin
`endif
               if (!tx_ready) begin
                  tx_we <= 1'b0;
                  state <= StDrain;
               end
            end
            StDrain: begin
               if (tx_ready) begin
`ifdef UART_ARB_PREFIX_EN
                  if (pfx_left == 2'd2) begin
                     tx_data  <= COLON;
                     tx_we    <= 1'b1;
                     pfx_left <= 2'd1;
                     state    <= StPfx1;
                  end else if (pfx_left == 2'd1) begin
                     tx_data          <= data_hold;
                     tx_we            <= 1'b1;
                     req_ready[owner] <= 1'b1;
                     pfx_left         <= 2'd0;
                     state            <= StIssue;
                  end else begin
`else
                  begin
`endif
                     state <= StIdle;
                     if (tx_data == NL) begin
                        locked <= 1'b0;
                     end
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=3, LOCK_TIMEOUT=8) with a transmitter model.
// Optional feature macro: UART_ARB_PREFIX_EN (enables the prefix sequence and model rule).
module tb_uart_tx_arbiter;

   localparam int N  = 3;
   localparam int LT = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   req_valid;
   logic [23:0]  req_data;
   logic [2:0]   req_ready;
   logic [7:0]   tx_data;
   logic         tx_we;
   logic         tx_ready;
   logic [1:0]   owner;
   logic         locked;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ        (N),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_we     (tx_we),
      .tx_ready  (tx_ready),
      .owner     (owner),
      .locked    (locked)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Requester byte queues; valid/data follow the queue heads.
   logic [7:0] qbuf [3][64];
   int         qh [3];
   int         qt [3];

   always_comb begin
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < 3; i++) begin
         if (qh[i] < qt[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = qbuf[i][qh[i]];
         end
      end
   end

   task automatic push(input int r, input logic [7:0] b);
      qbuf[r][qt[r]] = b;
      qt[r]++;
   endtask

   task automatic load_str(input int r, input logic [63:0] d, input int n);
      for (int k = 0; k < n; k++) push(r, d[8*(n-1-k) +: 8]);
   endtask

   // Accept monitor: pops the accepted byte and logs the requester index.
   int acc_log [1024];
   int acc_n = 0;
   always @(negedge clk) begin
      if (rst_n && req_ready != 3'b000) begin
         check("ready_onehot", 32'($countones(req_ready)), 32'd1);
         for (int i = 0; i < 3; i++) begin
            if (req_ready[i]) begin
               qh[i]++;
               acc_log[acc_n] = i;
               acc_n++;
            end
         end
      end
   end

   // Transmitter model: logs a byte on WE while ready, drops ready after tx_lat cycles,
   // keeps it low for tx_busy+1 cycles.
   int         tx_lat = 0;
   int         tx_busy = 1;
   int         ph;
   int         tcnt;
   logic [7:0] cap;
   logic [7:0] tx_log [4096];
   int         tx_n = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       <= 0;
         tcnt     <= 0;
         tx_ready <= 1'b1;
      end else begin
         if (ph != 0 && tx_we) check("tx_data_stable", 32'(tx_data), 32'(cap));
         case (ph)
            0: if (tx_we && tx_ready) begin
               tx_log[tx_n] <= tx_data;
               tx_n         <= tx_n + 1;
               cap          <= tx_data;
               if (tx_lat == 0) begin
                  tx_ready <= 1'b0;
                  tcnt     <= tx_busy;
                  ph       <= 2;
               end else begin
                  tcnt <= tx_lat - 1;
                  ph   <= 1;
               end
            end
            1: if (tcnt == 0) begin
               tx_ready <= 1'b0;
               tcnt     <= tx_busy;
               ph       <= 2;
            end else tcnt <= tcnt - 1;
            default: if (tcnt == 0) begin
               tx_ready <= 1'b1;
               ph       <= 0;
            end else tcnt <= tcnt - 1;
         endcase
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         qh[i] = 0;
         qt[i] = 0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for n transmitted bytes, then a quiet period, then checks the count.
   task automatic wait_tx(input int base, input int n, input string name);
      int cyc = 0;
      while ((tx_n - base) < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (40) @(negedge clk);
      check({name, "_count"}, 32'(tx_n - base), 32'(n));
   endtask

   // Reference model: expected byte stream and accept order from the arbitration rules.
   logic [7:0] exp_b [128];
   int         exp_o [64];
   task automatic run_model(output int ne, output int na);
      int mh [3];
      int ptr, own, g;
      bit lk, fnd, any;
      logic [7:0] b;
      for (int i = 0; i < 3; i++) mh[i] = 0;
      ptr = 0; own = 0; lk = 0; ne = 0; na = 0;
      for (int step = 0; step < 64; step++) begin
         any = 0;
         for (int i = 0; i < 3; i++) if (mh[i] < qt[i]) any = 1;
         if (any) begin
            if (lk && mh[own] < qt[own]) begin
               g = own;
            end else begin
               lk = 0;  // either unlocked already or the lock times out
               fnd = 0;
               g = 0;
               for (int k = 0; k < 3; k++) begin
                  int idx = (ptr + k) % 3;
                  if (!fnd && mh[idx] < qt[idx]) begin
                     g = idx;
                     fnd = 1;
                  end
               end
            end
`ifdef UART_ARB_PREFIX_EN
            if (!lk) begin
               exp_b[ne] = 8'h30 + 8'(g); ne++;
               exp_b[ne] = 8'h3A;         ne++;
            end
`endif
            b = qbuf[g][mh[g]];
            mh[g]++;
            exp_b[ne] = b; ne++;
            exp_o[na] = g; na++;
            own = g;
            ptr = (g + 1) % 3;
            lk  = (b != 8'h0A);
         end
      end
   endtask

   typedef struct packed {
      logic [63:0]  d0;
      logic [3:0]   n0;
      logic [63:0]  d1;
      logic [3:0]   n1;
      logic [63:0]  d2;
      logic [3:0]   n2;
      logic [127:0] ex;
      logic [4:0]   nx;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int base, abase, ne, na, we_cyc, cyc, k, rel, len;
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int base, abase, ne, na, we_cyc, cyc, k, rel, len;

      // {req0 bytes, req1 bytes, req2 bytes, expected tx stream}, all loaded at once from reset.
      vecs[0] = '{d0: 64'h41420A, n0: 4'd3, d1: 64'h78, n1: 4'd1, d2: 64'h0, n2: 4'd0,
                  ex: 128'h41420A78, nx: 5'd4};                       // "AB\n" vs "x"
      vecs[1] = '{d0: 64'h610A620A, n0: 4'd4, d1: 64'h630A640A, n1: 4'd4,
                  d2: 64'h650A660A, n2: 4'd4,
                  ex: 128'h610A630A650A620A640A660A, nx: 5'd12};      // line rotation 0,1,2
      vecs[2] = '{d0: 64'h6162, n0: 4'd2, d1: 64'h6364, n1: 4'd2, d2: 64'h0, n2: 4'd0,
                  ex: 128'h61626364, nx: 5'd4};                       // timeout hand-over
      vecs[3] = '{d0: 64'h0, n0: 4'd0, d1: 64'h710A, n1: 4'd2, d2: 64'h72, n2: 4'd1,
                  ex: 128'h710A72, nx: 5'd3};
      vecs[4] = '{d0: 64'h0A, n0: 4'd1, d1: 64'h0A, n1: 4'd1, d2: 64'h7A0A, n2: 4'd2,
                  ex: 128'h0A0A7A0A, nx: 5'd4};
      vecs[5] = '{d0: 64'h61, n0: 4'd1, d1: 64'h0, n1: 4'd0, d2: 64'h620A63, n2: 4'd3,
                  ex: 128'h61620A63, nx: 5'd4};                       // timeout then wrap

      // Reset state.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         qh[i] = 0;
         qt[i] = 0;
      end
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_tx_we", 32'(tx_we), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      do_reset();

`ifndef UART_ARB_PREFIX_EN
      // Single request, slow transmitter.
      tx_lat = 10; tx_busy = 2;
      base = tx_n;
      push(0, 8'h41);
      @(negedge clk);
      check("single_ready", 32'(req_ready), 32'b001);
      check("single_we", 32'(tx_we), 32'd1);
      check("single_data", 32'(tx_data), 32'h41);
      check("single_locked", 32'(locked), 32'd1);
      check("single_owner", 32'(owner), 32'd0);
      @(negedge clk);
      check("single_ready_pulse", 32'(req_ready), 32'd0);
      we_cyc = 1;
      while (tx_we && we_cyc < 100) begin
         we_cyc++;
         @(negedge clk);
      end
      check("single_we_cycles", 32'(we_cyc), 32'd12);
      check("single_tx_ready_low", 32'(tx_ready), 32'd0);
      check("single_logged", 32'(tx_log[base]), 32'h41);

      // Lock timeout: req0 quiet after 'a', req1 pending.
      do_reset();
      tx_lat = 0; tx_busy = 1;
      push(0, 8'h61);
      push(1, 8'h78);
      @(negedge clk);
      check("to_first_owner", 32'(owner), 32'd0);
      cyc = 0;
      while (tx_ready && cyc < 50) begin @(negedge clk); cyc++; end
      while (!tx_ready && cyc < 100) begin @(negedge clk); cyc++; end
      k = 0; rel = -1;
      while (!req_ready[1] && k < 50) begin
         @(negedge clk);
         k++;
         if (!locked && rel < 0) rel = k;
      end
      check("to_release_cycle", 32'(rel), 32'd9);
      check("to_grant_cycle", 32'(k), 32'd10);
      check("to_owner", 32'(owner), 32'd1);
      check("to_data", 32'(tx_data), 32'h78);
      check("to_relocked", 32'(locked), 32'd1);

      // Reset during DRAIN.
      do_reset();
      tx_lat = 0; tx_busy = 20;
      abase = acc_n;
      push(2, 8'h5A);
      cyc = 0;
      while (tx_ready && cyc < 50) begin @(negedge clk); cyc++; end
      @(negedge clk);
      check("mid_pre_owner", 32'(owner), 32'd2);
      check("mid_pre_locked", 32'(locked), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_tx_we", 32'(tx_we), 32'd0);
      check("mid_req_ready", 32'(req_ready), 32'd0);
      check("mid_locked", 32'(locked), 32'd0);
      check("mid_owner", 32'(owner), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_accepts", 32'(acc_n - abase), 32'd1);
      push(1, 8'h6B);
      @(negedge clk);
      check("mid_after_ready", 32'(req_ready), 32'b010);
      check("mid_after_owner", 32'(owner), 32'd1);
      check("mid_after_data", 32'(tx_data), 32'h6B);

      // Table vectors.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         tx_lat = 1; tx_busy = 2;
         base = tx_n;
         load_str(0, vecs[v].d0, int'(vecs[v].n0));
         load_str(1, vecs[v].d1, int'(vecs[v].n1));
         load_str(2, vecs[v].d2, int'(vecs[v].n2));
         wait_tx(base, int'(vecs[v].nx), "vec");
         for (int b = 0; b < int'(vecs[v].nx); b++) begin
            check($sformatf("vec%0d_byte%0d", v, b), 32'(tx_log[base + b]),
                  32'(vecs[v].ex[8*(int'(vecs[v].nx)-1-b) +: 8]));
         end
      end
`else
      // Prefix on a new line: "hi\n" from requester 1.
      tx_lat = 0; tx_busy = 1;
      base = tx_n; abase = acc_n;
      push(1, 8'h68); push(1, 8'h69); push(1, 8'h0A);
      wait_tx(base, 5, "pfx");
      check("pfx_b0", 32'(tx_log[base]), 32'h31);
      check("pfx_b1", 32'(tx_log[base + 1]), 32'h3A);
      check("pfx_b2", 32'(tx_log[base + 2]), 32'h68);
      check("pfx_b3", 32'(tx_log[base + 3]), 32'h69);
      check("pfx_b4", 32'(tx_log[base + 4]), 32'h0A);
      check("pfx_accepts", 32'(acc_n - abase), 32'd3);
      check("pfx_unlocked", 32'(locked), 32'd0);
`endif

      // Randomized contention against the reference model.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         tx_lat  = $urandom_range(0, 3);
         tx_busy = $urandom_range(0, 4);
         for (int i = 0; i < 3; i++) begin
            len = $urandom_range(0, 6);
            for (int j = 0; j < len; j++) begin
               if ($urandom_range(0, 3) == 0) push(i, 8'h0A);
               else push(i, 8'h61 + 8'($urandom_range(0, 25)));
            end
         end
         run_model(ne, na);
         base = tx_n; abase = acc_n;
         wait_tx(base, ne, "rnd");
         for (int b = 0; b < ne; b++) begin
            check($sformatf("rnd%0d_byte%0d", r, b), 32'(tx_log[base + b]), 32'(exp_b[b]));
         end
         check("rnd_accept_count", 32'(acc_n - abase), 32'(na));
         for (int a = 0; a < na; a++) begin
            check($sformatf("rnd%0d_owner%0d", r, a), 32'(acc_log[abase + a]), 32'(exp_o[a]));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
